pifo_drain_ctrl: RTL and testbench

//  Dequeue-side controller for a PIFO register block. Watches the PIFO head (valid/rank/meta),

---
 rtl/pifo_pkg.sv | 14 +
 rtl/pifo_skid_fifo.sv | 54 +++++
 rtl/pifo_drain_ctrl.sv | 109 ++++++++++
 tb/tb_pifo_drain_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_pkg.sv
// Shared definitions for the PIFO dequeue-side logic: field width defaults and
// the drain controller state encoding.
package pifo_pkg;

    localparam int RANK_WIDTH_DEF = 8;
    localparam int META_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        COOL  = 2'd0,
        READY = 2'd1,
        ISSUE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/pifo_skid_fifo.sv
// Two-entry FIFO that holds dequeued PIFO entries until the downstream consumer
// accepts them. The head entry is presented combinationally from storage, so a
// push into an empty FIFO is visible on dout right after the push edge.
module pifo_skid_fifo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign dout    = mem[rd_ptr];
    assign do_pop  = valid && ready;
    assign do_push = push && !full;

    // Storage, pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pifo_drain_ctrl.sv
// Dequeue-side controller for a PIFO. Removes the head only after it has been
// quiet for a settle window following any insert or remove, and forwards each
// removed entry to a valid/ready consumer through a 2-entry buffer.
module pifo_drain_ctrl
    import pifo_pkg::*;
#(
    parameter int RANK_WIDTH    = RANK_WIDTH_DEF,
    parameter int META_WIDTH    = META_WIDTH_DEF,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  pifo_valid,
    input  logic [RANK_WIDTH-1:0] pifo_rank,
    input  logic [META_WIDTH-1:0] pifo_meta,
    input  logic                  pifo_insert,
    output logic                  pifo_remove,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RANK_WIDTH-1:0] m_rank,
    output logic [META_WIDTH-1:0] m_meta,
    output logic [CNT_WIDTH-1:0]  deq_count,
    output logic                  busy
);

    localparam int         DW          = RANK_WIDTH + META_WIDTH;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    drain_state_t    state;
    drain_state_t    state_next;
    logic [3:0]      settle_cnt;
    logic [3:0]      settle_next;
    logic            issue_go;
    logic            buf_full;
    logic [DW-1:0]   buf_dout;

    // The head captured on the READY->ISSUE edge goes straight into the buffer.
    pifo_skid_fifo #(
        .WIDTH (DW)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_go),
        .din   ({pifo_rank, pifo_meta}),
        .ready (m_ready),
        .valid (m_valid),
        .dout  (buf_dout),
        .full  (buf_full)
    );

    assign m_rank = buf_dout[DW-1:META_WIDTH];
    assign m_meta = buf_dout[META_WIDTH-1:0];
    assign busy   = (state != READY) || m_valid;

    // Next-state logic: an insert always wins over a pending remove and restarts the settle window.
    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        issue_go    = 1'b0;
        case (state)
            COOL: begin
                if (pifo_insert) begin
                    settle_next = SETTLE_LOAD;
                end else if (settle_cnt == 4'd0) begin
                    state_next = READY;
                end else begin
                    settle_next = settle_cnt - 4'd1;
                end
            end
            READY: begin
                if (pifo_insert) begin
                    state_next  = COOL;
                    settle_next = SETTLE_LOAD;
                end else if (pifo_valid && en && !buf_full) begin
                    state_next = ISSUE;
                    issue_go   = 1'b1;
                end
            end
            ISSUE: begin
                state_next  = COOL;
                settle_next = SETTLE_LOAD;
            end
            default: begin
                state_next  = COOL;
                settle_next = SETTLE_LOAD;
            end
        endcase
    end

    // State, settle counter, registered remove pulse and removal counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= COOL;
            settle_cnt  <= SETTLE_LOAD;
            pifo_remove <= 1'b0;
            deq_count   <= '0;
        end else begin
            state       <= state_next;
            settle_cnt  <= settle_next;
            pifo_remove <= issue_go;
            if (state == ISSUE) begin
                deq_count <= deq_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pifo_drain_ctrl.sv
// Bench for pifo_drain_ctrl. The PIFO is modelled as an unordered bag whose head
// is the minimum rank; every removal must take the current minimum and every
// delivered entry must match the removals in order.
module tb_pifo_drain_ctrl;

    localparam int SETTLE = 2;

    typedef struct packed {
        logic [7:0] rank;
        logic [7:0] meta;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pifo_valid;
    logic [7:0]  pifo_rank;
    logic [7:0]  pifo_meta;
    logic        pifo_insert;
    logic        pifo_remove;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_rank;
    logic [7:0]  m_meta;
    logic [31:0] deq_count;
    logic        busy;

    int     errors = 0;
    int     checks = 0;
    int     cycleCount = 0;
    int     removeCount = 0;
    int     deliveredCount = 0;
    int     lastRemoveCycle = 0;
    bit     haveLast = 1'b0;
    logic [7:0] nextMeta = 8'd1;
    entry_t pifoQ[$];
    entry_t expQ[$];
    entry_t deliveredLog[$];
    entry_t pendingIns;

    pifo_drain_ctrl #(
        .RANK_WIDTH    (8),
        .META_WIDTH    (8),
        .SETTLE_CYCLES (SETTLE),
        .CNT_WIDTH     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pifo_valid  (pifo_valid),
        .pifo_rank   (pifo_rank),
        .pifo_meta   (pifo_meta),
        .pifo_insert (pifo_insert),
        .pifo_remove (pifo_remove),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_rank      (m_rank),
        .m_meta      (m_meta),
        .deq_count   (deq_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Index of the minimum-rank entry (first inserted wins ties), -1 when empty.
    function automatic int headIndex();
        int best = -1;
        foreach (pifoQ[i]) begin
            if (best < 0 || pifoQ[i].rank < pifoQ[best].rank) best = i;
        end
        return best;
    endfunction

    task automatic driveHead();
        int h = headIndex();
        if (h < 0) begin
            pifo_valid = 1'b0;
            pifo_rank  = 8'd0;
            pifo_meta  = 8'd0;
        end else begin
            pifo_valid = 1'b1;
            pifo_rank  = pifoQ[h].rank;
            pifo_meta  = pifoQ[h].meta;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_remove"}, 32'(pifo_remove), 32'd0);
        checkOutput({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        checkOutput({tag, "_m_rank"}, 32'(m_rank), 32'd0);
        checkOutput({tag, "_m_meta"}, 32'(m_meta), 32'd0);
        checkOutput({tag, "_deq_count"}, deq_count, 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic clearTracking();
        expQ.delete();
        deliveredLog.delete();
        removeCount    = 0;
        deliveredCount = 0;
        haveLast       = 1'b0;
    endtask

    // Advance one clock with the current inputs, updating the PIFO model and scoreboard.
    task automatic applyStimulus();
        logic   remS;
        logic   hsS;
        logic   insS;
        entry_t got;
        entry_t want;
        int     h;
        remS = pifo_remove;
        hsS  = m_valid && m_ready;
        insS = pifo_insert;
        got.rank = m_rank;
        got.meta = m_meta;
        @(posedge clk);
        #1;
        cycleCount++;
        if (remS) begin
            removeCount++;
            if (haveLast) begin
                checkOutput("remove_spacing", 32'((cycleCount - lastRemoveCycle) >= SETTLE + 2), 32'd1);
            end
            haveLast        = 1'b1;
            lastRemoveCycle = cycleCount;
            h = headIndex();
            checkOutput("remove_nonempty", 32'(h >= 0), 32'd1);
            if (h >= 0) begin
                expQ.push_back(pifoQ[h]);
                pifoQ.delete(h);
            end
        end
        if (insS) begin
            pifoQ.push_back(pendingIns);
            pifo_insert = 1'b0;
        end
        if (hsS) begin
            deliveredCount++;
            deliveredLog.push_back(got);
            checkOutput("delivery_pending", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                want = expQ.pop_front();
                checkOutput("delivered_entry", 32'(got), 32'(want));
            end
        end
        driveHead();
    endtask

    task automatic insertEntry(input logic [7:0] r);
        pendingIns.rank = r;
        pendingIns.meta = nextMeta;
        nextMeta        = nextMeta + 8'd1;
        pifo_insert     = 1'b1;
        applyStimulus();
    endtask

    task automatic preload(input logic [7:0] r);
        entry_t e;
        e.rank   = r;
        e.meta   = nextMeta;
        nextMeta = nextMeta + 8'd1;
        pifoQ.push_back(e);
    endtask

    task automatic resetDut();
        rst         = 1'b1;
        en          = 1'b0;
        m_ready     = 1'b0;
        pifo_insert = 1'b0;
        driveHead();
        repeat (2) @(posedge clk);
        #1;
        checkReset("rst");
        rst = 1'b0;
        clearTracking();
    endtask

    task automatic runUntilDelivered(input int target, input int budget, input string tag);
        int n = 0;
        while (deliveredCount < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(deliveredCount), 32'(target));
    endtask

    initial begin
        int    base;
        int    remBase;
        int    insCycle;
        int    n;
        int    insDone;
        int    sorted[$];
        logic [7:0] r;

        // Test 1: ranks {5,3,9} drained in ascending order.
        pifoQ.delete();
        preload(8'd5);
        preload(8'd3);
        preload(8'd9);
        resetDut();
        en      = 1'b1;
        m_ready = 1'b1;
        runUntilDelivered(3, 200, "t1_delivered");
        checkOutput("t1_first", 32'(deliveredLog[0].rank), 32'd3);
        checkOutput("t1_second", 32'(deliveredLog[1].rank), 32'd5);
        checkOutput("t1_third", 32'(deliveredLog[2].rank), 32'd9);
        repeat (10) applyStimulus();
        checkOutput("t1_deq_count", deq_count, 32'd3);
        checkOutput("t1_removes", 32'(removeCount), 32'd3);
        checkOutput("t1_busy_idle", 32'(busy), 32'd0);

        // Test 2: stalled consumer lets only two entries leave the PIFO.
        en = 1'b0;
        sorted.delete();
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom_range(0, 255));
            sorted.push_back(int'(r));
            insertEntry(r);
        end
        sorted.sort();
        repeat (8) applyStimulus();
        m_ready = 1'b0;
        en      = 1'b1;
        remBase = removeCount;
        base    = deliveredCount;
        repeat (40) applyStimulus();
        checkOutput("t2_removes_blocked", 32'(removeCount - remBase), 32'd2);
        checkOutput("t2_m_valid", 32'(m_valid), 32'd1);
        checkOutput("t2_head_rank", 32'(m_rank), 32'(sorted[0]));
        m_ready = 1'b1;
        runUntilDelivered(base + 4, 300, "t2_delivered");
        for (int i = 0; i < 4; i++) begin
            checkOutput("t2_order", 32'(deliveredLog[base + i].rank), 32'(sorted[i]));
        end
        repeat (10) applyStimulus();
        checkOutput("t2_deq_count", deq_count, 32'd7);

        // Test 3: insert coincides with the remove condition and must win.
        en = 1'b0;
        insertEntry(8'd20);
        repeat (10) applyStimulus();
        checkOutput("t3_ready_idle", 32'(busy), 32'd0);
        remBase = removeCount;
        base    = deliveredCount;
        en      = 1'b1;
        insertEntry(8'd7);
        insCycle = cycleCount;
        checkOutput("t3_no_remove_on_insert", 32'(pifo_remove), 32'd0);
        n = 0;
        while (removeCount == remBase && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("t3_remove_seen", 32'(removeCount - remBase), 32'd1);
        checkOutput("t3_settle_wait", 32'((lastRemoveCycle - insCycle) >= SETTLE + 2), 32'd1);
        runUntilDelivered(base + 2, 200, "t3_delivered");
        checkOutput("t3_inserted_first", 32'(deliveredLog[base].rank), 32'd7);
        checkOutput("t3_then_old", 32'(deliveredLog[base + 1].rank), 32'd20);

        // Test 4: empty PIFO for 50 cycles.
        remBase = removeCount;
        repeat (50) applyStimulus();
        checkOutput("t4_no_remove", 32'(removeCount - remBase), 32'd0);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_m_valid", 32'(m_valid), 32'd0);
        checkOutput("t4_deq_count", deq_count, 32'd9);

        // Test 5: enable dropped while a remove is in flight.
        en = 1'b0;
        insertEntry(8'd40);
        insertEntry(8'd30);
        insertEntry(8'd50);
        repeat (6) applyStimulus();
        en      = 1'b1;
        base    = deliveredCount;
        remBase = removeCount;
        n = 0;
        while (pifo_remove !== 1'b1 && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("t5_issue_seen", 32'(pifo_remove), 32'd1);
        en = 1'b0;
        repeat (40) applyStimulus();
        checkOutput("t5_single_remove", 32'(removeCount - remBase), 32'd1);
        checkOutput("t5_delivered", 32'(deliveredCount - base), 32'd1);
        checkOutput("t5_rank", 32'(deliveredLog[base].rank), 32'd30);
        checkOutput("t5_deq_count", deq_count, 32'd10);
        checkOutput("t5_pifo_left", 32'(pifoQ.size()), 32'd2);

        // Test 6: reset asserted during ISSUE discards everything in flight.
        en = 1'b1;
        n = 0;
        while (pifo_remove !== 1'b1 && n < 60) begin
            applyStimulus();
            n++;
        end
        checkOutput("t6_issue_seen", 32'(pifo_remove), 32'd1);
        rst = 1'b1;
        #1;
        checkReset("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearTracking();
        checkOutput("t6_busy_after", 32'(busy), 32'd1);
        checkOutput("t6_remove_after", 32'(pifo_remove), 32'd0);
        runUntilDelivered(2, 200, "t6_delivered");
        checkOutput("t6_first", 32'(deliveredLog[0].rank), 32'd40);
        checkOutput("t6_second", 32'(deliveredLog[1].rank), 32'd50);
        repeat (10) applyStimulus();
        checkOutput("t6_deq_count", deq_count, 32'd2);

        // Random traffic: random consumer stalls and inserts against the min-rank model.
        pifoQ.delete();
        for (int i = 0; i < 6; i++) preload(8'($urandom_range(0, 255)));
        resetDut();
        en      = 1'b1;
        insDone = 0;
        n       = 0;
        while (n < 3000 && !(insDone == 4 && deliveredCount == 10)) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (insDone < 4 && pifo_remove === 1'b0 && pifo_insert === 1'b0 && $urandom_range(0, 9) == 0) begin
                pendingIns.rank = 8'($urandom_range(0, 255));
                pendingIns.meta = nextMeta;
                nextMeta        = nextMeta + 8'd1;
                pifo_insert     = 1'b1;
                insDone++;
            end
            applyStimulus();
            n++;
        end
        checkOutput("rnd_delivered", 32'(deliveredCount), 32'd10);
        repeat (5) applyStimulus();
        checkOutput("rnd_deq_count", deq_count, 32'd10);
        checkOutput("rnd_pifo_empty", 32'(pifoQ.size()), 32'd0);
        checkOutput("rnd_scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
